// File: rtl/debounce_bank_pkg.sv
// Shared game-timing defaults and types for the button conditioning path.
package debounce_bank_pkg;

  localparam int unsigned DB_PERIOD       = 5;
  localparam int unsigned DB_REPEAT_DELAY = 20;
  localparam int unsigned DB_REPEAT_RATE  = 8;

  typedef enum logic [1:0] {
    RPT_IDLE  = 2'd0,
    RPT_DELAY = 2'd1,
    RPT_RATE  = 2'd2
  } rpt_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, debounce counter, press/release
// strobes and the auto-repeat FSM.
module debounce_channel
  import debounce_bank_pkg::*;
#(
  parameter int unsigned PERIOD       = DB_PERIOD,
  parameter int unsigned PERIOD_W     = 5,
  parameter int unsigned REPEAT_DELAY = DB_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE  = DB_REPEAT_RATE,
  parameter int unsigned REPEAT_W     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  input  logic repeat_en,
  output logic btn_db,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  logic                s0;
  logic                s1;
  logic [PERIOD_W-1:0] cnt;
  logic [REPEAT_W-1:0] rcnt;
  rpt_state_e          state;
  logic                flip;
  logic                rise;
  logic                fall;

  // The debounced level flips on the edge where the counter has seen
  // PERIOD consecutive disagreeing samples; strobes share that edge.
  always_comb begin
    flip = (s1 != btn_db) && (cnt == PERIOD_W'(PERIOD - 1));
    rise = flip && s1;
    fall = flip && !s1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0          <= 1'b0;
      s1          <= 1'b0;
      cnt         <= '0;
      btn_db      <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      s0          <= button;
      s1          <= s0;
      btn_press   <= rise;
      btn_release <= fall;
      if (s1 == btn_db) begin
        cnt <= '0;
      end else if (flip) begin
        btn_db <= s1;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Non-IDLE states only exist while btn_db is high, so the press/release
  // updates take priority over the per-state counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RPT_IDLE;
      rcnt       <= '0;
      btn_repeat <= 1'b0;
    end else begin
      btn_repeat <= 1'b0;
      if (rise) begin
        state      <= RPT_DELAY;
        rcnt       <= '0;
        btn_repeat <= 1'b1;
      end else if (fall) begin
        state <= RPT_IDLE;
        rcnt  <= '0;
      end else begin
        unique case (state)
          RPT_IDLE: begin
            rcnt <= '0;
          end
          RPT_DELAY: begin
            if (!repeat_en) begin
              rcnt <= '0;
            end else if (rcnt == REPEAT_W'(REPEAT_DELAY - 1)) begin
              state      <= RPT_RATE;
              rcnt       <= '0;
              btn_repeat <= 1'b1;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          RPT_RATE: begin
            if (!repeat_en) begin
              state <= RPT_DELAY;
              rcnt  <= '0;
            end else if (rcnt == REPEAT_W'(REPEAT_RATE - 1)) begin
              rcnt       <= '0;
              btn_repeat <= 1'b1;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          default: begin
            state <= RPT_IDLE;
            rcnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel button conditioner: one independent debounce_channel per
// button bit, sharing clock and reset.
module debounce_bank
  import debounce_bank_pkg::*;
#(
  parameter int unsigned CHANNELS     = 5,
  parameter int unsigned PERIOD       = DB_PERIOD,
  parameter int unsigned PERIOD_W     = 5,
  parameter int unsigned REPEAT_DELAY = DB_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE  = DB_REPEAT_RATE,
  parameter int unsigned REPEAT_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] button,
  input  logic [CHANNELS-1:0] repeat_en,
  output logic [CHANNELS-1:0] btn_db,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_repeat
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .PERIOD      (PERIOD),
      .PERIOD_W    (PERIOD_W),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE),
      .REPEAT_W    (REPEAT_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .button     (button[g]),
      .repeat_en  (repeat_en[g]),
      .btn_db     (btn_db[g]),
      .btn_press  (btn_press[g]),
      .btn_release(btn_release[g]),
      .btn_repeat (btn_repeat[g])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: behavioural model checked every cycle plus
// directed scenarios with hand-computed timing expectations.
module tb_debounce_bank;

  localparam int NCH    = 5;
  localparam int PERIOD = 5;
  localparam int RDELAY = 20;
  localparam int RRATE  = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] button;
  logic [NCH-1:0] repeat_en;
  logic [NCH-1:0] btn_db, btn_press, btn_release, btn_repeat;

  int checks = 0;
  int errors = 0;

  debounce_bank #(
    .CHANNELS    (NCH),
    .PERIOD      (PERIOD),
    .PERIOD_W    (5),
    .REPEAT_DELAY(RDELAY),
    .REPEAT_RATE (RRATE),
    .REPEAT_W    (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .button     (button),
    .repeat_en  (repeat_en),
    .btn_db     (btn_db),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: sync is a two-deep delay line; the debounced level flips once the
  // synced level has disagreed for PERIOD consecutive edges; repeat pulses
  // come from the age since the press (or since repeat was last disabled).
  bit m_s0[NCH], m_s1[NCH], m_db[NCH], m_pr[NCH], m_rl[NCH], m_rp[NCH];
  int run[NCH], age[NCH];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        m_s0[i] = 0; m_s1[i] = 0; m_db[i] = 0;
        m_pr[i] = 0; m_rl[i] = 0; m_rp[i] = 0;
        run[i] = 0; age[i] = 0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        bit differs, flip;
        differs = (m_s1[i] != m_db[i]);
        flip    = differs && (run[i] + 1 == PERIOD);
        run[i]  = (differs && !flip) ? run[i] + 1 : 0;
        m_pr[i] = flip && m_s1[i];
        m_rl[i] = flip && !m_s1[i];
        if (flip) m_db[i] = m_s1[i];
        m_s1[i] = m_s0[i];
        m_s0[i] = button[i];
        if (m_pr[i]) begin
          age[i] = 0; m_rp[i] = 1;
        end else if (!m_db[i] || !repeat_en[i]) begin
          age[i] = 0; m_rp[i] = 0;
        end else begin
          age[i]++;
          m_rp[i] = (age[i] >= RDELAY) && ((age[i] - RDELAY) % RRATE == 0);
        end
      end
    end
  end

  always @(posedge clk) begin
    logic [NCH-1:0] e_db, e_pr, e_rl, e_rp;
    #1;
    for (int i = 0; i < NCH; i++) begin
      e_db[i] = m_db[i]; e_pr[i] = m_pr[i]; e_rl[i] = m_rl[i]; e_rp[i] = m_rp[i];
    end
    chk("model_db",      32'(btn_db),      32'(e_db));
    chk("model_press",   32'(btn_press),   32'(e_pr));
    chk("model_release", 32'(btn_release), 32'(e_rl));
    chk("model_repeat",  32'(btn_repeat),  32'(e_rp));
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_press(input int ch, output bit ok);
    ok = 0;
    for (int k = 0; k < 30; k++) begin
      edge_sample();
      if (btn_press[ch]) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_press ch%0d actual=timeout required=press within 30", ch);
    end
  endtask

  initial begin
    int  offs[$];
    int  cnt;
    bit  ok;
    int  exp4[6] = '{0, 20, 28, 36, 44, 52};
    int  exp5[5] = '{0, 20, 28, 60, 68};

    // Reset with all buttons held
    rst_n = 1'b0; button = '1; repeat_en = '0;
    idle(4);
    #1;
    chk("reset_outputs", 32'({btn_db, btn_press, btn_release, btn_repeat}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      edge_sample();
      if (k == 6) chk("reset_db_edge6", 32'(btn_db), 32'h00);
      if (k == 7) begin
        chk("reset_db_edge7",    32'(btn_db),    32'h1F);
        chk("reset_press_edge7", 32'(btn_press), 32'h1F);
      end
    end
    @(negedge clk);
    button = '0;
    idle(15);

    // Bounce on channel 0, then settle high
    button[0] = 1; idle(2);
    button[0] = 0; idle(2);
    button[0] = 1; idle(2);
    button[0] = 0; idle(2);
    chk("bounce_db_stable", 32'(btn_db[0]), 32'h0);
    button[0] = 1;
    cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      edge_sample();
      if (btn_press[0]) cnt++;
      if (k == 6) chk("bounce_db_edge6", 32'(btn_db[0]), 32'h0);
      if (k == 7) chk("bounce_db_edge7", 32'(btn_db[0]), 32'h1);
    end
    chk("bounce_press_count", 32'(cnt), 32'd1);

    // Release after a 40-cycle hold
    idle(40);
    button[0] = 0;
    cnt = 0;
    for (int k = 1; k <= 7; k++) begin
      edge_sample();
      if (btn_release[0]) cnt++;
      if (k == 6) chk("release_db_edge6", 32'(btn_db[0]), 32'h1);
      if (k == 7) chk("release_db_edge7", 32'(btn_db[0]), 32'h0);
    end
    chk("release_pulse_count", 32'(cnt), 32'd1);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      edge_sample();
      if (btn_repeat[0]) cnt++;
    end
    chk("release_no_repeat", 32'(cnt), 32'd0);

    // Auto-repeat on channel 1
    @(negedge clk);
    repeat_en[1] = 1; button[1] = 1;
    wait_press(1, ok);
    if (ok) begin
      offs.delete();
      for (int o = 0; o < 60; o++) begin
        if (btn_repeat[1]) offs.push_back(o);
        if (o < 59) edge_sample();
      end
      chk("repeat_count", 32'(offs.size()), 32'd6);
      for (int j = 0; j < 6 && j < offs.size(); j++)
        chk($sformatf("repeat_offset%0d", j), 32'(offs[j]), 32'(exp4[j]));
    end
    @(negedge clk);
    button[1] = 0;
    idle(20);

    // Repeat disabled mid-hold, then re-enabled
    button[1] = 1;
    wait_press(1, ok);
    if (ok) begin
      offs.delete();
      for (int o = 0; o <= 70; o++) begin
        if (btn_repeat[1]) offs.push_back(o);
        @(negedge clk);
        if (o == 30) repeat_en[1] = 0;
        if (o == 40) repeat_en[1] = 1;
        if (o < 70) edge_sample();
      end
      chk("redis_count", 32'(offs.size()), 32'd5);
      for (int j = 0; j < 5 && j < offs.size(); j++)
        chk($sformatf("redis_offset%0d", j), 32'(offs[j]), 32'(exp5[j]));
    end
    button[1] = 0; repeat_en[1] = 0;
    idle(20);

    // Concurrent press on 2 and 4 with release on 3
    button[3] = 1;
    idle(20);
    button[2] = 1; button[4] = 1; button[3] = 0;
    for (int k = 1; k <= 7; k++) edge_sample();
    chk("concur_press",   32'(btn_press),   32'b10100);
    chk("concur_release", 32'(btn_release), 32'b01000);
    @(negedge clk);
    button = '0;
    idle(20);

    // Randomised traffic with a mid-hold reset
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < NCH; i++) begin
        int p;
        p = ((n / 500) % 2 == 0) ? 3 : 30;
        if ($urandom_range(0, 99) < p) button[i] = ~button[i];
        if ($urandom_range(0, 199) == 0) repeat_en[i] = ~repeat_en[i];
      end
      if (n == 2000) begin
        button = '1;
        idle(12);
        rst_n = 1'b0;
        #1;
        chk("midhold_reset_outputs", 32'({btn_db, btn_press, btn_release, btn_repeat}), 32'h0);
        idle(2);
        rst_n = 1'b1;
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
